// File: rtl/btm_pkg.sv
// -----------------------------------------------------------------------------
// btm_pkg
// Shared definitions for the truncating sequential divider (btd_trunc_seq).
//
// Contents
//   btd_state_t : controller states IDLE, CALC, DONE, plus ROUND when the
//                 optional quotient rounding stage is built (BTD_ROUND_EN).
//   cnt_width() : width of an iteration counter that must hold 0..iters.
//
// Build option
//   BTD_ROUND_EN : adds the ROUND state used by the rounding stage.
// -----------------------------------------------------------------------------
package btm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      DONE  = 2'd2
`ifdef BTD_ROUND_EN
      ,
      ROUND = 2'd3
`endif
   } btd_state_t;

   // The counter has to reach the terminal value 'iters' itself, hence +1.
   function automatic int cnt_width(input int iters);
      if (iters < 1) begin
         return 1;
      end
      return $clog2(iters + 1);
   endfunction

endpackage

// File: rtl/btd_trunc_step.sv
// -----------------------------------------------------------------------------
// btd_trunc_step
// One restoring shift-subtract step of an unsigned divider (pure combinational).
//
// Ports
//   rem      [W-1:0] in  : partial remainder, always < div on entry
//   div      [W-1:0] in  : divisor
//   din               in  : next dividend bit (MSB-first)
//   rem_next [W-1:0] out : partial remainder after this step
//   q_bit             out : quotient bit produced by this step
// -----------------------------------------------------------------------------
module btd_trunc_step #(
   parameter int W = 9
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] div,
   input  logic         din,
   output logic [W-1:0] rem_next,
   output logic         q_bit
);

   logic [W:0]   shifted;
   logic [W-1:0] diff;

   assign shifted = {rem, din};
   assign q_bit   = (shifted >= {1'b0, div});
   // rem < div guarantees shifted < 2*div, so whenever the subtraction is
   // taken the true difference fits in W bits; modulo-2^W arithmetic on the
   // low bits is therefore exact.
   assign diff     = shifted[W-1:0] - div;
   assign rem_next = q_bit ? diff : shifted[W-1:0];

endmodule

// File: rtl/btd_trunc_seq.sv
// -----------------------------------------------------------------------------
// btd_trunc_seq
// Sequential unsigned divider on truncated operands. The DAC low bits of both
// operands are dropped, the truncated dividend is divided by the truncated
// divisor one quotient bit per cycle (restoring, MSB first) and the remainder
// is rescaled by DAC zero bits on output.
//
// Parameters
//   DA  : dividend / quotient width
//   DB  : divisor / remainder width
//   DAC : LSBs dropped from each operand (0..DB-2)
//
// Ports
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   a [DA-1:0] in  : dividend
//   b [DB-1:0] in  : divisor
//   in_valid   in  : a/b valid
//   in_ready   out : operand pair can be accepted (IDLE only)
//   q [DA-1:0] out : quotient (zero-extended truncated quotient)
//   r [DB-1:0] out : remainder, {r_t, DAC zeros}
//   dz         out : divide-by-zero flag for the presented result
//   out_valid  out : q/r/dz valid (DONE)
//   out_ready  in  : consumer takes the result
//
// Build option
//   BTD_ROUND_EN : inserts a ROUND cycle after the iterations which increments
//                  the quotient (saturating) when 2*r_t >= b_t. Without it the
//                  quotient is truncated. The divide-by-zero path is the same
//                  in both builds.
//
// Timing (accepting edge = T): results appear after edge T+DA-DAC+1 (T+DA-DAC+2
// with rounding); a zero truncated divisor yields its result after edge T+2.
// -----------------------------------------------------------------------------
module btd_trunc_seq
   import btm_pkg::*;
#(
   parameter int DA  = 10,
   parameter int DB  = 10,
   parameter int DAC = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DA-1:0] a,
   input  logic [DB-1:0] b,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DA-1:0] q,
   output logic [DB-1:0] r,
   output logic          dz,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int AW = DA - DAC;               // truncated dividend / quotient width
   localparam int BW = DB - DAC;               // truncated divisor / remainder width
   localparam int CW = cnt_width(AW);
   localparam logic [CW-1:0] CNT_LAST = CW'(AW);

   btd_state_t    state_reg, state_next;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
   // after AW iterations this register holds q_t.
   logic [AW-1:0] a_sh_reg,  a_sh_next;
   logic [BW-1:0] b_t_reg,   b_t_next;
   logic [BW-1:0] rem_reg,   rem_next;
   logic [CW-1:0] cnt_reg,   cnt_next;
   logic [DA-1:0] q_reg,     q_next;
   logic [DB-1:0] r_reg,     r_next;
   logic          dz_reg,    dz_next;
   // Keeps in_ready low until the first edge after reset release.
   logic          init_reg;

   logic          b_zero;
   logic [BW-1:0] step_rem;
   logic          step_q;

   assign b_zero = (b_t_reg == '0);

   btd_trunc_step #(
      .W (BW)
   ) u_step (
      .rem      (rem_reg),
      .div      (b_t_reg),
      .din      (a_sh_reg[AW-1]),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

`ifdef BTD_ROUND_EN
   logic          round_up;
   logic [AW-1:0] q_rnd;

   assign round_up = ({rem_reg, 1'b0} >= {1'b0, b_t_reg});
   assign q_rnd    = (round_up && (a_sh_reg != {AW{1'b1}})) ? a_sh_reg + AW'(1) : a_sh_reg;
`endif

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_sh_reg  <= '0;
         b_t_reg   <= '0;
         rem_reg   <= '0;
         cnt_reg   <= '0;
         q_reg     <= '0;
         r_reg     <= '0;
         dz_reg    <= 1'b0;
         init_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_sh_reg  <= a_sh_next;
         b_t_reg   <= b_t_next;
         rem_reg   <= rem_next;
         cnt_reg   <= cnt_next;
         q_reg     <= q_next;
         r_reg     <= r_next;
         dz_reg    <= dz_next;
         init_reg  <= 1'b1;
      end
   end

   // ------------------------------------------------------ next state / outputs
   always_comb begin
      state_next = state_reg;
      a_sh_next  = a_sh_reg;
      b_t_next   = b_t_reg;
      rem_next   = rem_reg;
      cnt_next   = cnt_reg;
      q_next     = q_reg;
      r_next     = r_reg;
      dz_next    = dz_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;

      case (state_reg)
         IDLE: begin
            in_ready = init_reg;
            if (init_reg && in_valid) begin
               // Shift-then-cast reads every operand bit and drops the DAC LSBs.
               a_sh_next  = AW'(a >> DAC);
               b_t_next   = BW'(b >> DAC);
               rem_next   = '0;
               cnt_next   = '0;
               state_next = CALC;
            end
         end

         CALC: begin
            if (cnt_reg == CNT_LAST) begin
               if (b_zero) begin
                  // a_sh_reg was never shifted on this path, so it still holds a_t.
                  q_next     = DA'({AW{1'b1}});
                  r_next     = DB'(BW'(a_sh_reg)) << DAC;
                  dz_next    = 1'b1;
                  state_next = DONE;
               end else begin
`ifdef BTD_ROUND_EN
                  state_next = ROUND;
`else
                  q_next     = DA'(a_sh_reg);
                  r_next     = DB'(rem_reg) << DAC;
                  dz_next    = 1'b0;
                  state_next = DONE;
`endif
               end
            end else if (b_zero) begin
               // Nothing to iterate: jump straight to the finishing cycle.
               cnt_next = CNT_LAST;
            end else begin
               a_sh_next = (a_sh_reg << 1) | AW'(step_q);
               rem_next  = step_rem;
               cnt_next  = cnt_reg + CW'(1);
            end
         end

`ifdef BTD_ROUND_EN
         ROUND: begin
            q_next     = DA'(q_rnd);
            r_next     = DB'(rem_reg) << DAC;
            dz_next    = 1'b0;
            state_next = DONE;
         end
`endif

         DONE: begin
            out_valid = 1'b1;
            // Returning to IDLE first means a new pair can never be taken in
            // the handshake cycle.
            if (out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign q  = q_reg;
   assign r  = r_reg;
   assign dz = dz_reg;

endmodule
